// File: rtl/jtopl_timer_pkg.sv
// ---------------------------------------------------------------------------
// jtopl_timer_pkg
// Shared defaults for the timer bank and a helper that sizes the common
// prescaler. Imported by jtopl_timer_bank and jtopl_timer_ch.
// ---------------------------------------------------------------------------
package jtopl_timer_pkg;

    localparam int CH_DEFAULT    = 2;
    localparam int CW_DEFAULT    = 8;
    localparam int PW_DEFAULT    = 2;
    localparam int PSTEP_DEFAULT = 2;

    // The prescaler must be wide enough for the slowest channel, which is
    // the last one: it needs PW + (CH-1)*PSTEP low bits all set.
    function automatic int prescWidth(input int ch, input int pw, input int pstep);
        return pw + (ch - 1) * pstep;
    endfunction

endpackage

// File: rtl/jtopl_timer_ch.sv
// ---------------------------------------------------------------------------
// jtopl_timer_ch
// One timer channel: up-counter with reload, overflow pulse, sticky flag,
// load edge detection and optional one-shot stop state.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   en_i        channel enable pulse from the shared prescaler
//   value_i     reload / start value
//   load_i      run bit (level); a 0->1 edge loads value_i
//   clrFlag_i   clears the sticky flag (wins over a coincident set)
//   oneshot_i   when set, the channel stops after its overflow reload
//   flag_o      raw (unmasked) sticky flag
//   overflow_o  one-clock overflow pulse
// ---------------------------------------------------------------------------
module jtopl_timer_ch
    import jtopl_timer_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [CW-1:0] value_i,
    input  logic          load_i,
    input  logic          clrFlag_i,
    input  logic          oneshot_i,
    output logic          flag_o,
    output logic          overflow_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic          ovf_q, ovf_d;
    logic          loadLast_q, loadLast_d;
    logic          stopped_q, stopped_d;
    logic          loadRise;

    // Next-state logic. A load edge always takes priority over a counting
    // enable in the same cycle. Counting requires load_i high and the
    // channel not parked by one-shot mode; the reload on overflow uses the
    // live value_i so software can change the period on the fly.
    always_comb begin
        loadRise   = load_i & ~loadLast_q;
        loadLast_d = load_i;
        cnt_d      = cnt_q;
        ovf_d      = 1'b0;
        stopped_d  = stopped_q;
        if (loadRise) begin
            cnt_d     = value_i;
            stopped_d = 1'b0;
        end else if (en_i && load_i && !stopped_q) begin
            if (&cnt_q) begin
                cnt_d     = value_i;
                ovf_d     = 1'b1;
                stopped_d = oneshot_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        flag_d = flag_q | ovf_d;
        if (clrFlag_i) begin
            flag_d = 1'b0;
        end
    end

    // State registers. Clearing the load history in reset makes a load
    // that is already high right after reset count as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            ovf_q      <= 1'b0;
            loadLast_q <= 1'b0;
            stopped_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            ovf_q      <= ovf_d;
            loadLast_q <= loadLast_d;
            stopped_q  <= stopped_d;
        end
    end

    assign flag_o     = flag_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/jtopl_timer_bank.sv
// ---------------------------------------------------------------------------
// jtopl_timer_bank
// Bank of CH independent timers sharing one free-running prescaler. Channel
// k advances once every 2^(PW+k*PSTEP) ticks, where tick = cenop & zero.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   cenop     operator clock enable
//   zero      slot-zero marker
//   value     per-channel start values, channel k in [k*CW +: CW]
//   load      per-channel run bit
//   clr_flag  per-channel flag clear
//   flagen    per-channel flag mask for flag/irq_n
//   clr_all   clears every flag
//   oneshot   per-channel one-shot mode (only with JTOPL_TIMER_ONESHOT_EN)
//   flag      masked flags
//   overflow  one-clock overflow pulses
//   irq_n     low while any masked flag is set
//
// Build option: define JTOPL_TIMER_ONESHOT_EN to add the oneshot input;
// without it every channel auto-reloads.
// ---------------------------------------------------------------------------
module jtopl_timer_bank
    import jtopl_timer_pkg::*;
#(
    parameter int CH    = CH_DEFAULT,
    parameter int CW    = CW_DEFAULT,
    parameter int PW    = PW_DEFAULT,
    parameter int PSTEP = PSTEP_DEFAULT
) (
    input  logic [0:0]     clk,
    input  logic           rst_n,
    input  logic           cenop,
    input  logic           zero,
    input  logic [CH*CW-1:0] value,
    input  logic [CH-1:0]  load,
    input  logic [CH-1:0]  clr_flag,
    input  logic [CH-1:0]  flagen,
    input  logic           clr_all,
`ifdef JTOPL_TIMER_ONESHOT_EN
    input  logic [CH-1:0]  oneshot,
`endif
    output logic [CH-1:0]  flag,
    output logic [CH-1:0]  overflow,
    output logic           irq_n
);

    localparam int PRW = prescWidth(CH, PW, PSTEP);

    logic [PRW-1:0] presc_q, presc_d;
    logic           tick;
    logic [CH-1:0]  chEn;
    logic [CH-1:0]  flagRaw;
    logic [CH-1:0]  oneshotEff;

`ifdef JTOPL_TIMER_ONESHOT_EN
    assign oneshotEff = oneshot;
`else
    assign oneshotEff = '0;
`endif

    // The prescaler only ever advances on ticks; channel loads never touch
    // it, so every channel keeps a fixed phase relative to reset.
    always_comb begin
        tick    = cenop & zero;
        presc_d = presc_q + PRW'(tick);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : gCh
        localparam int             LOWBITS = PW + k * PSTEP;
        localparam logic [PRW-1:0] MASK    = {PRW{1'b1}} >> (PRW - LOWBITS);

        // Channel k fires on the tick that would carry out of its low bits.
        assign chEn[k] = tick & ((presc_q & MASK) == MASK);

        jtopl_timer_ch #(
            .CW (CW)
        ) uCh (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (chEn[k]),
            .value_i    (value[k*CW +: CW]),
            .load_i     (load[k]),
            .clrFlag_i  (clr_flag[k] | clr_all),
            .oneshot_i  (oneshotEff[k]),
            .flag_o     (flagRaw[k]),
            .overflow_o (overflow[k])
        );
    end

    // Masking happens only here so a pending flag reappears when re-enabled.
    assign flag  = flagRaw & flagen;
    assign irq_n = ~|flag;

endmodule

// File: doc/jtopl_timer_bank.md
JTOPL_TIMER_BANK -- requirements
Module: jtopl_timer_bank

Interface
REQ-001 SHALL have parameter CH, default 2: number of timer channels, 1..8.
REQ-002 SHALL have parameter CW, default 8: counter width per channel.
REQ-003 SHALL have parameter PW, default 2: prescaler bits for channel 0.
REQ-004 SHALL have parameter PSTEP, default 2: extra prescaler bits per channel index; channel k divides ticks by 2^(PW+k*PSTEP).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port cenop  in  1  operator clock enable.
REQ-008 SHALL have port zero  in  1  slot-zero marker; tick = cenop & zero.
REQ-009 SHALL have port value  in  CH*CW  start values; channel k in bits [k*CW +: CW].
REQ-010 SHALL have port load  in  CH  per-channel run bit (level).
REQ-011 SHALL have port clr_flag  in  CH  per-channel flag clear (level).
REQ-012 SHALL have port flagen  in  CH  per-channel flag enable for irq.
REQ-013 SHALL have port clr_all  in  1  clears every flag.
REQ-014 SHALL have port flag  out  CH  masked flags: raw flag & flagen.
REQ-015 SHALL have port overflow  out  CH  one-clk overflow pulse per channel.
REQ-016 SHALL have port irq_n  out  1  low while any bit of flag is set.

Function
REQ-017 SHALL keep one free-running prescaler, width PW+(CH-1)*PSTEP, incremented on every tick; load SHALL never reset it.
REQ-018 SHALL give channel k an enable pulse on a tick where the low PW+k*PSTEP prescaler bits are all ones.
REQ-019 SHALL load cnt[k] with value[k] on the clk after a 0->1 transition of load[k]; this load SHALL override a coincident enable.
REQ-020 SHALL increment cnt[k] by one on a channel-k enable only while load[k]=1; with load[k]=0 the counter SHALL hold.
REQ-021 SHALL, when cnt[k] is all ones at an enabled increment, reload cnt[k] with the current value[k] (not a stored copy) and register overflow[k]=1 for exactly one clk.
REQ-022 SHALL set raw flag[k] on the same edge that overflow[k] goes high; flag[k] and overflow[k] SHALL therefore first be visible together.
REQ-023 SHALL clear raw flag[k] when clr_flag[k] or clr_all is 1; a clear SHALL win over a coincident set.
REQ-024 SHALL make flagen affect only outputs flag and irq_n, never the raw flag state; re-enabling SHALL expose a flag that is still pending.
REQ-025 SHALL drive irq_n combinationally from the masked flags; there SHALL be no extra latency.
REQ-026 SHALL run channels fully independently; simultaneous overflows on several channels SHALL each pulse and set flags on the same edge.
REQ-027 SHALL accept value[k] = all ones: the channel then overflows on every channel-k enable.

Reset
REQ-028 SHALL, while rst_n=0 at a clk edge, zero the prescaler, all cnt, raw flags, overflow and the stored load history; irq_n SHALL be 1.
REQ-029 SHALL treat load already high on the first clk after reset release as a 0->1 transition, loading value.
REQ-030 SHALL let reset mid-count abandon the count with no overflow pulse.

Configuration
REQ-031 SHALL support macro JTOPL_TIMER_ONESHOT_EN: when defined, add input oneshot (CH bits); a channel with oneshot[k]=1 stops after its overflow reload and holds until the next 0->1 on load[k].
REQ-032 SHALL, without JTOPL_TIMER_ONESHOT_EN, omit the oneshot port, and every channel SHALL auto-reload.

Structure
REQ-033 SHALL place the defaults for CH, CW, PW and PSTEP, plus the prescaler-width function, in package jtopl_timer_pkg.
REQ-034 SHALL implement each channel in sub-module jtopl_timer_ch, instantiated CH times by generate; it takes cnt, the flag, load-edge detection and the oneshot state.

Verification
REQ-035 SHALL cover: defaults, value[0]=8'hFE, load[0]=1, tick every clk -> overflow[0] pulses after 8 ticks, then every 8 ticks.
REQ-036 SHALL cover: value[1]=8'hFF, load[1]=1 -> overflow[1] every 16 ticks; flag[1]=1 with flagen[1]=1 drives irq_n=0.
REQ-037 SHALL cover: load[0] dropped mid-count at cnt=8'h80, then raised again -> no increment while low; on the rise, cnt reloads value and the prescaler phase is unchanged.
REQ-038 SHALL cover: clr_flag[0]=1 on the overflow edge -> flag[0] stays 0 and overflow[0] still pulses; with flagen[0]=0, raw flag set and irq_n=1 until flagen[0]=1.
REQ-039 SHALL cover: rst_n=0 for one clk mid-count -> all outputs 0, irq_n=1, prescaler 0, no overflow pulse.
REQ-040 SHALL cover, with JTOPL_TIMER_ONESHOT_EN and oneshot[0]=1: exactly one overflow[0], the counter holds, and the next 0->1 on load[0] rearms it.
